screen_console_writer: RTL and testbench
========================================

Name: screen_console_writer

Overview:
Writer-side producer for the character screen memory (COLS x ROWS tiles, row-major, addr = row*COLS + col). Accepts a valid/ready stream of character/command tokens, keeps a text cursor and issues one-per-cycle writes to the screen memory write port. Clear-screen and scroll-up run as multi-cycle FSM operations; scroll uses the memory's second read port, which reads combinationally in the same cycle.

Parameters:
COLS, 40, tiles per row
ROWS, 30, rows per screen; Nloc = COLS*ROWS (1200)
Dbits, 4, character code width
BLANK, 0, code written by clear/scroll fill

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  token valid
in_ready  out  1  block can accept a token this cycle
in_cmd  in  2  0=PUT, 1=NEWLINE, 2=CLEAR, 3=HOME
in_char  in  Dbits  character for PUT
mem_wr  out  1  write strobe to screen memory (registered)
mem_waddr  out  $clog2(Nloc)  write address (registered)
mem_wdata  out  Dbits  write data (registered)
mem_raddr  out  $clog2(Nloc)  read address to second read port (combinational from state)
mem_rdata  in  Dbits  read data, valid same cycle as mem_raddr
cursor_col  out  $clog2(COLS)  current column
cursor_row  out  $clog2(ROWS)  current row
busy  out  1  high in CLEAR or SCROLL; in_ready = ~busy

Behaviour:
- Reset: state IDLE, cursor (0,0), mem_wr=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, busy=0, in_ready=1. Reset mid-CLEAR/SCROLL aborts; memory left partially updated.
- Accept = in_valid & in_ready. Ignored tokens produce no effect.
- PUT at (c,r): next cycle mem_wr=1, waddr=r*COLS+c, wdata=in_char. Cursor: c<COLS-1 -> c+1; else col 0, row r+1; if r=ROWS-1 -> cursor (0,ROWS-1) and enter SCROLL the cycle after the write.
- NEWLINE: no write; col 0; row+1, or, if on last row, cursor stays (0,ROWS-1) and enter SCROLL.
- HOME: cursor (0,0), no write. All single-cycle; back-to-back tokens accepted every cycle in IDLE.
- CLEAR: busy; index i=0..Nloc-1, one per cycle: registered write waddr=i, wdata=BLANK. Cursor (0,0). Nloc write cycles; in_ready high the cycle after last write is issued.
- SCROLL: phase COPY i=0..Nloc-COLS-1: mem_raddr=i+COLS, registered write waddr=i, wdata=mem_rdata. Phase FILL i=Nloc-COLS..Nloc-1: write BLANK. Nloc write cycles total; no read/write address overlap within a cycle.
- mem_wr=0 every cycle without a write. Counters saturate at Nloc-1 then return to IDLE; never wrap.
- States: IDLE, CLEAR, SCROLL_COPY, SCROLL_FILL.

Optional Feature:
CONSOLE_CLEAR_ON_RESET_EN: defined -> on reset release, FSM enters CLEAR (busy=1, in_ready=0) and blanks all Nloc locations before first token. Undefined -> reset goes to IDLE; memory keeps its initial-file contents.

Decomposition:
- Package console_pkg: cmd enum (CMD_PUT, CMD_NEWLINE, CMD_CLEAR, CMD_HOME), state enum, default COLS/ROWS/BLANK constants.
- Sub-module console_cursor: col/row counters with advance, newline, home, and "scroll needed" flag output.

Test Plan:
- Reset, PUT 5 -> next cycle mem_wr=1, waddr=0, wdata=5; cursor (1,0).
- 40 back-to-back PUT 3 from (0,0) -> writes waddr 0..39 on consecutive cycles; cursor (0,1); no SCROLL.
- Cursor (7,2), NEWLINE then HOME -> no mem_wr; cursor (0,3) then (0,0).
- Cursor (10,10), CLEAR -> in_ready low; waddr 0..1199 wdata=0 on 1200 consecutive cycles; cursor (0,0); in_ready high next cycle.
- Cursor (39,29), PUT 9 -> write 1199=9; then SCROLL: first raddr=40, write waddr=0 wdata=rdata; last copy raddr=1199 to 1159; waddr 1160..1199 = 0; cursor (0,29).
- Reset asserted mid-SCROLL at i=500 -> next cycle mem_wr=0, busy=0, cursor (0,0); with CONSOLE_CLEAR_ON_RESET_EN, CLEAR sequence starts instead.

Source files
------------

// File: rtl/console_pkg.sv
// console_pkg: shared command codes, FSM state constants and default geometry for the console writer
package console_pkg;
  typedef enum logic [1:0] {CMD_PUT, CMD_NEWLINE, CMD_CLEAR, CMD_HOME} cmd_t;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_CLEAR = 2'd1, ST_COPY = 2'd2, ST_FILL = 2'd3;
  localparam int DEF_COLS = 40, DEF_ROWS = 30, DEF_DBITS = 4, DEF_BLANK = 0;
endpackage

// File: rtl/screen_console_writer_if.sv
// screen_console_writer_if: token stream, screen-memory ports and cursor/busy status of the console writer
interface screen_console_writer_if #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int Dbits = 4
);
  localparam int AW = $clog2(COLS * ROWS), CW = $clog2(COLS), RW = $clog2(ROWS);
  logic in_valid, in_ready;
  logic [1:0] in_cmd;
  logic [Dbits-1:0] in_char;
  logic mem_wr;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [Dbits-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] cursor_col;
  logic [RW-1:0] cursor_row;
  logic busy;
  modport slave (
    input in_valid, in_cmd, in_char, mem_rdata,
    output in_ready, mem_wr, mem_waddr, mem_wdata, mem_raddr, cursor_col, cursor_row, busy
  );
  modport master (
    output in_valid, in_cmd, in_char, mem_rdata,
    input in_ready, mem_wr, mem_waddr, mem_wdata, mem_raddr, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/console_cursor.sv
// console_cursor: text cursor column/row counters; flags when an advance or newline falls off the last row
module console_cursor #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          advance,
  input  logic          newline,
  input  logic          home,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          scroll
);
  logic last_col, last_row, wrap;
  assign last_col = col == CW'(COLS - 1);
  assign last_row = row == RW'(ROWS - 1);
  assign wrap = newline | (advance & last_col);
  assign scroll = wrap & last_row;
  always_ff @(posedge clock) begin
    if (reset | home) begin
      col <= '0;
      row <= '0;
    end else if (wrap) begin
      col <= '0;
      row <= last_row ? row : row + 1'b1;
    end else if (advance) begin
      col <= col + 1'b1;
    end
  end
endmodule

// File: rtl/screen_console_writer.sv
// screen_console_writer: token-driven writer for the character screen memory with clear and scroll-up FSM
// Build option: define CONSOLE_CLEAR_ON_RESET_EN to blank the whole screen on reset release.
module screen_console_writer
  import console_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int Dbits = DEF_DBITS,
  parameter int BLANK = DEF_BLANK
) (
  input logic clock,
  input logic reset,
  screen_console_writer_if.slave bus
);
  localparam int NLOC = COLS * ROWS, AW = $clog2(NLOC), CW = $clog2(COLS), RW = $clog2(ROWS);
`ifdef CONSOLE_CLEAR_ON_RESET_EN
  localparam logic [1:0] RESET_ST = ST_CLEAR;
`else
  localparam logic [1:0] RESET_ST = ST_IDLE;
`endif
  logic [1:0] state;
  logic [AW-1:0] idx, waddr, addr;
  logic [Dbits-1:0] wdata;
  logic wr, acc, adv, nl, clr, home, scroll, last, copy_last;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  assign bus.busy = state != ST_IDLE;
  assign bus.in_ready = ~bus.busy;
  assign acc = bus.in_valid & bus.in_ready;
  assign adv = acc & (bus.in_cmd == CMD_PUT);
  assign nl = acc & (bus.in_cmd == CMD_NEWLINE);
  assign clr = acc & (bus.in_cmd == CMD_CLEAR);
  assign home = acc & (bus.in_cmd == CMD_HOME) | clr;
  assign addr = AW'(row) * AW'(COLS) + AW'(col);
  assign last = idx == AW'(NLOC - 1);
  assign copy_last = idx == AW'(NLOC - COLS - 1);
  // read one row below the write target so the copy never touches its own source
  assign bus.mem_raddr = state == ST_COPY ? idx + AW'(COLS) : '0;
  assign bus.mem_wr = wr;
  assign bus.mem_waddr = waddr;
  assign bus.mem_wdata = wdata;
  assign bus.cursor_col = col;
  assign bus.cursor_row = row;
  console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clock(clock), .reset(reset), .advance(adv), .newline(nl), .home(home),
    .col(col), .row(row), .scroll(scroll)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RESET_ST;
      idx <= '0;
      wr <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (state == ST_IDLE) begin
      wr <= adv;
      idx <= '0;
      if (adv) begin
        waddr <= addr;
        wdata <= bus.in_char;
      end
      state <= clr ? ST_CLEAR : scroll ? ST_COPY : ST_IDLE;
    end else begin
      wr <= 1'b1;
      waddr <= idx;
      wdata <= state == ST_COPY ? bus.mem_rdata : Dbits'(BLANK);
      idx <= last ? idx : idx + 1'b1;
      state <= state == ST_COPY ? (copy_last ? ST_FILL : ST_COPY) : (last ? ST_IDLE : state);
    end
  end
endmodule

// File: tb/tb_screen_console_writer.sv
// tb_screen_console_writer: randomized bench with a row/column screen model for the console writer
module tb_screen_console_writer;
  import console_pkg::*;
  localparam int COLS = 40, ROWS = 30, NLOC = COLS * ROWS;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  screen_console_writer_if #(.COLS(COLS), .ROWS(ROWS), .Dbits(4)) bus();
  screen_console_writer #(.COLS(COLS), .ROWS(ROWS), .Dbits(4), .BLANK(0)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  logic [3:0] mem [NLOC];
  logic [3:0] scr [ROWS][COLS];
  int mcol = 0, mrow = 0, errors = 0, checks = 0;
`ifdef CONSOLE_CLEAR_ON_RESET_EN
  localparam logic RST_BUSY = 1'b1;
`else
  localparam logic RST_BUSY = 1'b0;
`endif
  always @(posedge clock) if (bus.mem_wr) mem[bus.mem_waddr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_raddr];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic void m_scroll();
    for (int r = 0; r < ROWS - 1; r++) scr[r] = scr[r + 1];
    for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = 4'd0;
  endfunction

  function automatic void m_clear();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) scr[r][c] = 4'd0;
    mcol = 0;
    mrow = 0;
  endfunction

  function automatic void m_step(input logic [1:0] cmd, input logic [3:0] ch);
    if (cmd == CMD_PUT) begin
      scr[mrow][mcol] = ch;
      if (mcol < COLS - 1) mcol++;
      else begin
        mcol = 0;
        if (mrow < ROWS - 1) mrow++; else m_scroll();
      end
    end else if (cmd == CMD_NEWLINE) begin
      mcol = 0;
      if (mrow < ROWS - 1) mrow++; else m_scroll();
    end else if (cmd == CMD_CLEAR) m_clear();
    else begin
      mcol = 0;
      mrow = 0;
    end
  endfunction

  task automatic send(input logic [1:0] cmd, input logic [3:0] ch);
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_cmd = cmd;
    bus.in_char = ch;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    m_step(cmd, ch);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (bus.busy) begin
      errors++;
      $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", bus.busy, n);
    end
  endtask

  task automatic check_cursor(input string name);
    checks++;
    if (bus.cursor_col !== 6'(mcol) || bus.cursor_row !== 5'(mrow)) begin
      errors++;
      $display("FAIL %s cursor: got (%0d,%0d) required (%0d,%0d)", name, bus.cursor_col, bus.cursor_row, mcol, mrow);
    end
  endtask

  task automatic check_screen(input string name);
    int bad = 0, first = -1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (mem[r * COLS + c] !== scr[r][c]) begin
          bad++;
          if (first < 0) first = r * COLS + c;
        end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s screen: %0d cells differ, first at %0d got %0h required %0h", name, bad, first,
               mem[first], scr[first / COLS][first % COLS]);
    end
    check_cursor(name);
  endtask

  task automatic goto(input int col, input int row);
    send(CMD_HOME, 4'd0);
    for (int i = 0; i < row; i++) send(CMD_NEWLINE, 4'd0);
    for (int i = 0; i < col; i++) send(CMD_PUT, 4'($urandom));
  endtask

  task automatic test_reset();
    for (int i = 0; i < NLOC; i++) begin
      mem[i] = 4'($urandom);
      scr[i / COLS][i % COLS] = mem[i];
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.mem_waddr !== 11'd0 || bus.mem_wdata !== 4'd0 || bus.mem_raddr !== 11'd0) begin
      errors++;
      $display("FAIL reset mem: wr=%0b waddr=%0d wdata=%0h raddr=%0d required 0 0 0 0",
               bus.mem_wr, bus.mem_waddr, bus.mem_wdata, bus.mem_raddr);
    end
    checks++;
    if (bus.busy !== RST_BUSY || bus.in_ready !== ~RST_BUSY) begin
      errors++;
      $display("FAIL reset status: busy=%0b in_ready=%0b required %0b %0b", bus.busy, bus.in_ready, RST_BUSY, ~RST_BUSY);
    end
    check_cursor("reset");
    @(negedge clock);
    reset = 1'b0;
`ifdef CONSOLE_CLEAR_ON_RESET_EN
    wait_idle();
    m_clear();
    @(posedge clock);
    #1;
    check_screen("reset_clear");
`endif
  endtask

  task automatic test_put();
    logic [3:0] ch;
    int a;
    send(CMD_PUT, 4'd5);
    checks++;
    if (bus.mem_wr !== 1'b1 || bus.mem_waddr !== 11'd0 || bus.mem_wdata !== 4'd5) begin
      errors++;
      $display("FAIL put_first: wr=%0b waddr=%0d wdata=%0h required 1 0 5", bus.mem_wr, bus.mem_waddr, bus.mem_wdata);
    end
    check_cursor("put_first");
    for (int i = 0; i < 6; i++) begin
      ch = 4'($urandom);
      a = mrow * COLS + mcol;
      send(CMD_PUT, ch);
      checks++;
      if (bus.mem_wr !== 1'b1 || bus.mem_waddr !== 11'(a) || bus.mem_wdata !== ch) begin
        errors++;
        $display("FAIL put_rand: wr=%0b waddr=%0d wdata=%0h required 1 %0d %0h", bus.mem_wr, bus.mem_waddr, bus.mem_wdata, a, ch);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ch;
    send(CMD_HOME, 4'd0);
    for (int i = 0; i < COLS; i++) begin
      ch = 4'($urandom);
      send(CMD_PUT, ch);
      checks++;
      if (bus.mem_wr !== 1'b1 || bus.mem_waddr !== 11'(i) || bus.mem_wdata !== ch) begin
        errors++;
        $display("FAIL b2b[%0d]: wr=%0b waddr=%0d wdata=%0h required 1 %0d %0h", i, bus.mem_wr, bus.mem_waddr, bus.mem_wdata, i, ch);
      end
    end
    checks++;
    if (bus.cursor_col !== 6'd0 || bus.cursor_row !== 5'd1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: cursor (%0d,%0d) busy=%0b required (0,1) 0", bus.cursor_col, bus.cursor_row, bus.busy);
    end
  endtask

  task automatic test_newline_home();
    goto(7, 2);
    send(CMD_NEWLINE, 4'd0);
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.cursor_col !== 6'd0 || bus.cursor_row !== 5'd3) begin
      errors++;
      $display("FAIL newline: wr=%0b cursor (%0d,%0d) required 0 (0,3)", bus.mem_wr, bus.cursor_col, bus.cursor_row);
    end
    send(CMD_HOME, 4'd0);
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.cursor_col !== 6'd0 || bus.cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL home: wr=%0b cursor (%0d,%0d) required 0 (0,0)", bus.mem_wr, bus.cursor_col, bus.cursor_row);
    end
    check_screen("newline_home");
  endtask

  task automatic test_clear();
    int bad = 0, badr = 0;
    goto(10, 10);
    send(CMD_CLEAR, 4'd0);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL clear_start: in_ready=%0b busy=%0b wr=%0b required 0 1 0", bus.in_ready, bus.busy, bus.mem_wr);
    end
    bus.in_valid = 1'b1;
    bus.in_cmd = CMD_PUT;
    bus.in_char = 4'd7;
    for (int k = 1; k <= NLOC; k++) begin
      @(posedge clock);
      #1;
      if (k == NLOC - 10) bus.in_valid = 1'b0;
      if (bus.mem_wr !== 1'b1 || bus.mem_waddr !== 11'(k - 1) || bus.mem_wdata !== 4'd0) bad++;
      if (bus.in_ready !== (k == NLOC)) badr++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_writes: %0d of %0d write cycles wrong, required 0", bad, NLOC);
    end
    checks++;
    if (badr != 0) begin
      errors++;
      $display("FAIL clear_ready: %0d cycles with wrong in_ready, required 0", badr);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL clear_end: wr=%0b required 0", bus.mem_wr);
    end
    check_screen("clear");
  endtask

  task automatic test_scroll();
    int bad = 0, badr = 0;
    goto(COLS - 1, ROWS - 1);
    send(CMD_PUT, 4'd9);
    checks++;
    if (bus.mem_wr !== 1'b1 || bus.mem_waddr !== 11'(NLOC - 1) || bus.mem_wdata !== 4'd9 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL scroll_put: wr=%0b waddr=%0d wdata=%0h busy=%0b required 1 %0d 9 1",
               bus.mem_wr, bus.mem_waddr, bus.mem_wdata, bus.busy, NLOC - 1);
    end
    for (int k = 1; k <= NLOC; k++) begin
      if (k - 1 < NLOC - COLS && bus.mem_raddr !== 11'(k - 1 + COLS)) badr++;
      @(posedge clock);
      #1;
      if (bus.mem_wr !== 1'b1 || bus.mem_waddr !== 11'(k - 1) || bus.mem_wdata !== scr[(k - 1) / COLS][(k - 1) % COLS]) bad++;
    end
    checks++;
    if (badr != 0) begin
      errors++;
      $display("FAIL scroll_raddr: %0d copy cycles with wrong raddr, required 0", badr);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL scroll_writes: %0d of %0d write cycles wrong, required 0", bad, NLOC);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL scroll_done: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clock);
    #1;
    check_screen("scroll");
  endtask

  task automatic test_random();
    int r;
    for (int t = 0; t < 60; t++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) @(posedge clock);
      r = $urandom_range(0, 19);
      send(r < 14 ? CMD_PUT : r < 17 ? CMD_NEWLINE : r < 19 ? CMD_HOME : CMD_CLEAR, 4'($urandom));
    end
    wait_idle();
    @(posedge clock);
    #1;
    check_screen("random");
  endtask

  task automatic test_reset_mid_scroll();
    wait_idle();
    goto(0, ROWS - 1);
    send(CMD_NEWLINE, 4'd0);
    repeat (500) @(posedge clock);
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.mem_raddr !== 11'(500 + COLS)) begin
      errors++;
      $display("FAIL mid_scroll: busy=%0b raddr=%0d required 1 %0d", bus.busy, bus.mem_raddr, 500 + COLS);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mcol = 0;
    mrow = 0;
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.busy !== RST_BUSY || bus.cursor_col !== 6'd0 || bus.cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL reset_abort: wr=%0b busy=%0b cursor (%0d,%0d) required 0 %0b (0,0)",
               bus.mem_wr, bus.busy, bus.cursor_col, bus.cursor_row, RST_BUSY);
    end
`ifdef CONSOLE_CLEAR_ON_RESET_EN
    wait_idle();
    m_clear();
    @(posedge clock);
    #1;
    check_screen("reset_abort_clear");
`endif
    send(CMD_PUT, 4'd6);
    checks++;
    if (bus.mem_wr !== 1'b1 || bus.mem_waddr !== 11'd0 || bus.mem_wdata !== 4'd6) begin
      errors++;
      $display("FAIL after_abort: wr=%0b waddr=%0d wdata=%0h required 1 0 6", bus.mem_wr, bus.mem_waddr, bus.mem_wdata);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_cmd = 2'd0;
    bus.in_char = 4'd0;
    test_reset();
    test_put();
    test_back_to_back();
    test_newline_home();
    test_clear();
    test_scroll();
    test_random();
    test_reset_mid_scroll();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
